// File: rtl/bcd_mul_pkg.sv
// bcd_mul_pkg: shared constants, types and helpers for the decimal multiplier front end.
`default_nettype none

package bcd_mul_pkg;

  localparam int NDIG  = 4;
  localparam int DIG_W = 4;
  localparam int MAG_W = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic             neg;
    logic [MAG_W-1:0] mag;
  } sd_t;

  function automatic logic has_bad_digit(input logic [NDIG*DIG_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i*DIG_W +: DIG_W] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sd_digit_recoder.sv
// sd_digit_recoder: maps one BCD digit plus incoming carry to a radix-10 signed digit in -5..+5.
`default_nettype none

module sd_digit_recoder
  import bcd_mul_pkg::*;
(
  input  logic [DIG_W-1:0] y_dig,
  input  logic             cin,
  output logic             neg,
  output logic [MAG_W-1:0] mag,
  output logic             cout
);

  logic [DIG_W:0] d;

  always_comb begin
    d    = {1'b0, y_dig} + {{DIG_W{1'b0}}, cin};
    neg  = 1'b0;
    mag  = d[MAG_W-1:0];
    cout = 1'b0;
    // Digits above 5 become (d - 10) with a carry; d = 10 is +0 with carry.
    case (d)
      5'd6:    begin mag = 3'd4; neg = 1'b1; cout = 1'b1; end
      5'd7:    begin mag = 3'd3; neg = 1'b1; cout = 1'b1; end
      5'd8:    begin mag = 3'd2; neg = 1'b1; cout = 1'b1; end
      5'd9:    begin mag = 3'd1; neg = 1'b1; cout = 1'b1; end
      5'd10:   begin mag = 3'd0; neg = 1'b0; cout = 1'b1; end
      default: begin end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bcd_operand_sequencer.sv
// bcd_operand_sequencer: accepts BCD operands, holds X and streams Y as signed digits, LSD first.
`default_nettype none

module bcd_operand_sequencer
  import bcd_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NDIG*DIG_W-1:0] x_bcd,
  input  logic [NDIG*DIG_W-1:0] y_bcd,
  output logic [NDIG*DIG_W-1:0] x_hold,
  output logic                  sd_valid,
  input  logic                  sd_ready,
  output logic                  sd_neg,
  output logic [MAG_W-1:0]      sd_mag,
  output logic [2:0]            sd_idx,
  output logic                  sd_last,
  output logic                  err
);

  localparam logic [2:0] LAST_IDX = 3'(NDIG);

  state_t                  state;
  logic [NDIG*DIG_W-1:0]   y_reg;
  logic                    carry;
  logic [2:0]              idx;
  sd_t                     rec;
  logic                    rec_cout;
  logic                    run;
  logic                    at_last;

  sd_digit_recoder u_rec (
    .y_dig (y_reg[DIG_W-1:0]),
    .cin   (carry),
    .neg   (rec.neg),
    .mag   (rec.mag),
    .cout  (rec_cout)
  );

  assign run      = (state == RUN);
  assign at_last  = (idx == LAST_IDX);
  assign in_ready = (state == IDLE);
  assign sd_valid = run;
  assign sd_idx   = idx;
  assign sd_last  = run && at_last;
  assign sd_neg   = run && !at_last && rec.neg;
  // The final position carries out the pending carry as a non-negative digit.
  assign sd_mag   = !run    ? '0 :
                    at_last ? {{(MAG_W-1){1'b0}}, carry} : rec.mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_hold <= '0;
      y_reg  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      err    <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (has_bad_digit(x_bcd) || has_bad_digit(y_bcd)) begin
              err <= 1'b1;
            end else begin
              x_hold <= x_bcd;
              y_reg  <= y_bcd;
              carry  <= 1'b0;
              idx    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (sd_ready) begin
            y_reg <= {{DIG_W{1'b0}}, y_reg[NDIG*DIG_W-1:DIG_W]};
            if (at_last) begin
              carry <= 1'b0;
              idx   <= '0;
              state <= IDLE;
            end else begin
              carry <= rec_cout;
              idx   <= idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/bcd_operand_sequencer.md
# bcd_operand_sequencer

Front-end stage of the parallel decimal multiplier. Accepts a 4-digit BCD multiplicand X and multiplier Y over a valid/ready handshake and checks both for invalid digits. It holds X stable for the 8421→4221 recoder, and recodes Y into radix-10 signed digits in {-5..+5}. The signed digits are streamed one per cycle, least-significant first, to the partial-product selector.

## Interface
- NDIG, 4: BCD digits per operand; the signed-digit stream has NDIG+1 digits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- x_bcd  in  4*NDIG  multiplicand, 8421 BCD.
- y_bcd  in  4*NDIG  multiplier, 8421 BCD.
- x_hold  out  4*NDIG  registered multiplicand, feeds the 4221 recoder.
- sd_valid  out  1  signed digit valid.
- sd_ready  in  1  downstream accepts the signed digit.
- sd_neg  out  1  digit sign (1 = negative); always 0 when sd_mag = 0.
- sd_mag  out  3  digit magnitude, 0..5.
- sd_idx  out  3  digit position, 0..NDIG.
- sd_last  out  1  high with digit NDIG.
- err  out  1  one-cycle pulse: the accepted operand pair contained a BCD digit > 9.

## Operation
- States: IDLE and RUN.
- in_ready = (state == IDLE). An accept is in_valid && in_ready on a rising edge.
- Accept with all 2*NDIG digits ≤ 9:
  - Load X into x_hold and Y into the Y shift register.
  - Clear the carry, set idx = 0, go to RUN.
- Accept with any digit > 9:
  - x_hold and the Y register are not updated.
  - err = 1 for the next cycle; stay in IDLE.
- RUN:
  - sd_valid = 1, and the outputs are combinational from the Y register, carry and idx.
  - A transfer is sd_valid && sd_ready.
  - On a transfer: shift Y right one digit, update the carry, idx += 1.
  - A transfer with idx == NDIG returns the block to IDLE.
- Recoding for idx < NDIG, with d = y_idx + c (0..10):
  - d ≤ 5: sd_neg = 0, sd_mag = d, c' = 0.
  - d ≥ 6: sd_mag = 10 − d, c' = 1, sd_neg = (sd_mag ≠ 0).
  - d = 10 therefore gives +0 with carry.
- Recoding for idx == NDIG: sd_neg = 0, sd_mag = c, sd_last = 1.
- Invariant: Σ (−1)^neg · mag · 10^idx == Y.
- x_hold is held unchanged from an accept until the next successful accept, including while in IDLE.

## Timing
- Reset values: in_ready = 1, sd_valid = 0, err = 0, sd_neg = 0, sd_mag = 0, sd_idx = 0, sd_last = 0, x_hold = 0. State = IDLE, carry = 0.
- Latency: an accept at edge k makes sd_valid = 1 and x_hold valid in cycle k+1.
- Throughput: NDIG+1 transfers per operand pair, at 1 digit/cycle with sd_ready held high. in_ready rises in the cycle after the sd_last transfer, so the pair-to-pair period is NDIG+2 cycles.
- Backpressure: while sd_valid && !sd_ready, all sd_* outputs and the internal state hold.
- sd_valid never drops without a transfer.
- err asserts in the cycle after the invalid accept only, and in_ready stays 1 during that cycle.
- rst_n asserted mid-RUN: immediate return to IDLE with reset values. No partial stream resumes after reset.

## Structure
- Package bcd_mul_pkg holds:
  - NDIG and the digit width constant (4).
  - The signed-digit magnitude width (3).
  - The state enum {IDLE, RUN}.
  - The signed-digit struct {neg, mag}.
- Sub-module sd_digit_recoder: combinational; inputs y digit (4 bits) and carry-in; outputs neg, mag and carry-out.
- The sequencer instantiates one sd_digit_recoder and contains the handshake FSM, the Y shift register, the carry flop and the idx counter.

## Test plan
- Y=1234, X=5678, sd_ready=1 -> digits (+4,+3,+2,+1,+0) at idx 0..4 in consecutive cycles; sd_last only at idx 4; x_hold=5678 from cycle k+1.
- Y=9999 -> (−1,+0,+0,+0,+1); the d=10 cases produce sd_neg=0 with carry.
- Y=0006 then Y=0555 back-to-back -> (−4,+1,+0,+0,+0), then (+5,+5,+5,+0,+0); second in_ready rises exactly NDIG+2 cycles after the first accept.
- Y=00A3 (invalid digit) -> err pulses 1 cycle, sd_valid stays 0, x_hold keeps its previous value, in_ready stays 1.
- Y=0007, sd_ready low for 3 cycles at idx 1 -> (−3,+1) held stable across the stall, then the stream completes correctly.
- rst_n low mid-stream at idx 2 -> outputs reset asynchronously; a following accept of Y=0001 streams (+1,0,0,0,0).
